// File: rtl/link_statistics_scanner.sv
// Histogram readout engine: sweeps every bin over the CSR port, rebuilds coherent 48-bit counts
// and streams them out as AXI-stream beats. Optional macro LINK_STATS_SCAN_DELTA_EN emits deltas.
module link_statistics_scanner #(
  parameter int ADDR_WIDTH   = 5,
  parameter int READ_LATENCY = 3,
  parameter int MAX_RETRY    = 3,
  parameter int CLEAR_WAIT   = 34
) (
  input  logic                  i_sysClk,
  input  logic                  i_sysReset,
  input  logic                  i_start,
  input  logic                  i_clearAfterScan,
  output logic                  o_busy,
  output logic                  o_scanDone,
  output logic                  o_csrStrobe,
  output logic [31:0]           o_csrData,
  input  logic [31:0]           i_statValue,
  output logic                  o_mTVALID,
  input  logic                  i_mTREADY,
  output logic [47:0]           o_mTDATA,
  output logic [ADDR_WIDTH-1:0] o_mTUSER,
  output logic                  o_mTLAST,
  output logic                  o_mTTORN
);

  localparam int CNT_MAX = (CLEAR_WAIT > READ_LATENCY) ? CLEAR_WAIT : READ_LATENCY;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int RETRY_W = $clog2(MAX_RETRY + 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_BIN = '1;

  typedef enum logic [2:0] {
    S_IDLE, S_RD_HI1, S_RD_LO, S_RD_HI2, S_CHECK, S_EMIT, S_CLEAR, S_WAIT_CLR
  } state_t;

  state_t                r_state, w_state_nxt;
  logic [CNT_W-1:0]      r_cnt;
  logic [ADDR_WIDTH-1:0] r_bin;
  logic [RETRY_W-1:0]    r_retry;
  logic [15:0]           r_hi1, r_hi2;
  logic [31:0]           r_lo;
  logic                  r_clr, r_torn, r_done;

  logic        w_rd_done, w_clr_done, w_last, w_retry_max, w_hi_match, w_handshake;
  logic [47:0] w_count, w_beat;

  assign w_rd_done   = (r_cnt == CNT_W'(READ_LATENCY));
  assign w_clr_done  = (r_cnt == CNT_W'(CLEAR_WAIT - 1));
  assign w_last      = (r_bin == LAST_BIN);
  assign w_retry_max = (r_retry == RETRY_W'(MAX_RETRY));
  assign w_hi_match  = (r_hi1 == r_hi2);
  assign w_handshake = (r_state == S_EMIT) && i_mTREADY;
  assign w_count     = {r_hi2, r_lo};

`ifdef LINK_STATS_SCAN_DELTA_EN
  logic [47:0] r_shadow [2**ADDR_WIDTH];

  // NOTE: the shadow must read as zero after reset, so unlike most RAMs it is reset explicitly.
  always_ff @(posedge i_sysClk or posedge i_sysReset) begin
    if (i_sysReset) begin
      for (int i = 0; i < 2**ADDR_WIDTH; i++) r_shadow[i] <= '0;
    end else if (w_handshake) begin
      r_shadow[r_bin] <= r_clr ? 48'd0 : w_count;
    end
  end

  assign w_beat = w_count - r_shadow[r_bin];
`else
  assign w_beat = w_count;
`endif

  always_ff @(posedge i_sysClk or posedge i_sysReset) begin
    if (i_sysReset) r_state <= S_IDLE;
    else            r_state <= w_state_nxt;
  end

  // NOTE: every signal driven here gets a default first so no path can infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:     if (i_start)    w_state_nxt = S_RD_HI1;
      S_RD_HI1:   if (w_rd_done)  w_state_nxt = S_RD_LO;
      S_RD_LO:    if (w_rd_done)  w_state_nxt = S_RD_HI2;
      S_RD_HI2:   if (w_rd_done)  w_state_nxt = S_CHECK;
      S_CHECK:    w_state_nxt = (w_hi_match || w_retry_max) ? S_EMIT : S_RD_LO;
      S_EMIT: begin
        if (i_mTREADY) begin
          if (!w_last)    w_state_nxt = S_RD_HI1;
          else if (r_clr) w_state_nxt = S_CLEAR;
          else            w_state_nxt = S_IDLE;
        end
      end
      S_CLEAR:    w_state_nxt = S_WAIT_CLR;
      S_WAIT_CLR: if (w_clr_done) w_state_nxt = S_IDLE;
      default:    w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    o_busy      = (r_state != S_IDLE);
    o_scanDone  = r_done;
    o_csrStrobe = 1'b0;
    o_csrData   = '0;
    o_mTVALID   = 1'b0;
    o_mTDATA    = '0;
    o_mTUSER    = '0;
    o_mTLAST    = 1'b0;
    o_mTTORN    = 1'b0;
    unique case (r_state)
      S_RD_HI1, S_RD_LO, S_RD_HI2: begin
        if (r_cnt == '0) begin
          o_csrStrobe                = 1'b1;
          o_csrData[ADDR_WIDTH:1]    = r_bin;
          o_csrData[0]               = (r_state != S_RD_LO);
        end
      end
      S_CLEAR: begin
        o_csrStrobe = 1'b1;
        o_csrData   = 32'h8000_0000;
      end
      S_EMIT: begin
        o_mTVALID = 1'b1;
        o_mTDATA  = w_beat;
        o_mTUSER  = r_bin;
        o_mTLAST  = w_last;
        o_mTTORN  = r_torn;
      end
      default: ;
    endcase
  end

  // Datapath: read sampling, retry bookkeeping and bin sequencing.
  always_ff @(posedge i_sysClk or posedge i_sysReset) begin
    if (i_sysReset) begin
      r_cnt   <= '0;
      r_bin   <= '0;
      r_retry <= '0;
      r_hi1   <= '0;
      r_hi2   <= '0;
      r_lo    <= '0;
      r_clr   <= 1'b0;
      r_torn  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= (w_state_nxt == S_IDLE) && (r_state == S_EMIT || r_state == S_WAIT_CLR);

      if (w_state_nxt != r_state)
        r_cnt <= '0;
      else if (r_state inside {S_RD_HI1, S_RD_LO, S_RD_HI2, S_WAIT_CLR})
        r_cnt <= r_cnt + CNT_W'(1);
      else
        r_cnt <= '0;

      unique case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_bin   <= '0;
            r_retry <= '0;
            r_torn  <= 1'b0;
            r_clr   <= i_clearAfterScan;
          end
        end
        S_RD_HI1: if (w_rd_done) r_hi1 <= i_statValue[15:0];
        S_RD_LO:  if (w_rd_done) r_lo  <= i_statValue;
        S_RD_HI2: if (w_rd_done) r_hi2 <= i_statValue[15:0];
        S_CHECK: begin
          r_torn <= !w_hi_match && w_retry_max;
          if (!w_hi_match && !w_retry_max) begin
            r_hi1   <= r_hi2;
            r_retry <= r_retry + RETRY_W'(1);
          end
        end
        S_EMIT: begin
          if (i_mTREADY && !w_last) begin
            r_bin   <= r_bin + ADDR_WIDTH'(1);
            r_retry <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
